instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Fetch stage of the 8-bit ExceptioNull core; sits directly upstream of control_unit.
//   Holds the program counter and issues one read at a time to instruction memory.
//   Passes each returned instruction, with its PC, to decode over a valid/ready handshake.
//   Takes PC redirects from the branch/jump resolver (J, JAL, BEQ, BNE) and discards any
//   wrong-path fetch.
// PARAMETERS
//   PC_W      8      program counter / imem address width
//   INSTR_W   8      instruction width (opcode = instr[7:4])
//   RESET_PC  8'h00  PC loaded on reset
// PORTS
//   clk             in   1        single clock, rising edge
//   rst_n           in   1        asynchronous, active-low reset
//   imem_req        out  1        read request; the request is accepted in the cycle it is high
//   imem_addr       out  PC_W     read address, equal to pc_q
//   imem_rvalid     in   1        read data valid; arrives at least 1 cycle after imem_req
//   imem_rdata      in   INSTR_W  read data
//   redirect_valid  in   1        load redirect_pc; flush the wrong path
//   redirect_pc     in   PC_W     redirect target
//   instr_valid     out  1        instr_out / instr_pc are valid for decode
//   instr_ready     in   1        decode accepts the instruction
//   instr_out       out  INSTR_W  instruction to control_unit
//   instr_pc        out  PC_W     PC of instr_out
//   instr_pc_next   out  PC_W     instr_pc+1 mod 2^PC_W (JAL link value)
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - pc_q=RESET_PC, state=FETCH, discard_q=0, valid_q=0.
//     - instr_out=0, instr_pc=0; imem_req is forced 0 while rst_n=0.
//   FSM states
//     - FETCH: imem_req=1, imem_addr=pc_q; next state WAIT.
//     - WAIT: imem_req=0. On imem_rvalid with discard_q=0: capture rdata into instr_out,
//       pc_q into instr_pc, set valid_q, pc_q<=pc_q+1 (wraps 2^PC_W-1 -> 0), go HOLD.
//       On imem_rvalid with discard_q=1: drop the data, clear discard_q, go FETCH.
//     - HOLD: instr_valid held high and instr_out held stable until instr_ready.
//       On a handshake: clear valid_q, go FETCH.
//   Outputs and throughput
//     - instr_valid = valid_q & ~redirect_valid (combinational kill). No handshake can
//       occur in a redirect cycle.
//     - Latency: imem_req to instr_valid = memory latency + 1 cycle.
//     - Best case is 1 instruction per 3 cycles (one outstanding request only).
//   Redirects (redirect_valid=1 has priority over every other event)
//     - FETCH: the request is still issued at the old pc_q; set discard_q, pc_q<=redirect_pc,
//       go WAIT.
//     - WAIT with no rvalid: set discard_q, pc_q<=redirect_pc, stay in WAIT.
//     - WAIT with rvalid in the same cycle: drop the data, discard_q=0, pc_q<=redirect_pc,
//       go FETCH.
//     - HOLD: clear valid_q and the held instruction is never delivered;
//       pc_q<=redirect_pc, go FETCH.
//     - redirect_valid in consecutive cycles: the last target wins.
//   Boundary conditions
//     - imem_rvalid is ignored in FETCH and HOLD (a stray response has no effect).
//     - instr_ready is ignored while valid_q=0.
//     - rst_n asserted mid-operation: all state returns to reset values at once.
//       imem is reset by the same rst_n, so no response is outstanding afterwards.
//     - Redirect to the current PC is legal and refetches it.
// STRUCTURE
//   - Shared package isa_pkg:
//     - INSTR_W, PC_W;
//     - opcode localparams OP_MOVE=4'h0 .. OP_LI=4'hF (shared with control_unit);
//     - fetch state enum {FETCH, WAIT, HOLD}.
//   - Single module with no sub-module.
//   - One registered FSM, one pc register, one output register, one discard flag.
// TESTING
//   1. Reset, 1-cycle imem holding 8'h1D at 0x00, 8'h2D at 0x01, ready=1:
//      - imem_addr goes 00 then 01;
//      - instr_out goes 1D then 2D, with instr_pc 00 then 01;
//      - there are 3 cycles between valid pulses.
//   2. Backpressure: ready=0 for 5 cycles with 8'h1D held:
//      - instr_valid stays 1 and instr_out stays 1D;
//      - no imem_req is issued;
//      - after ready=1, the next fetch has addr=01.
//   3. Redirect in WAIT to 8'h40, with the old response 8'hAA arriving next cycle:
//      - AA is never presented;
//      - the next imem_addr is 40 and instr_pc=40.
//   4. Redirect to 8'h80 in HOLD while ready=1 in the same cycle:
//      - instr_valid=0 in that cycle;
//      - the next fetch addr is 80.
//   5. PC wrap: RESET_PC=8'hFF:
//      - the first instruction has instr_pc=FF and instr_pc_next=00;
//      - the second fetch addr is 00.
//   6. Assert rst_n in WAIT with a 3-cycle memory:
//      - outputs reach reset values asynchronously;
//      - after release, the first imem_addr is RESET_PC.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the ExceptioNull 8-bit core: widths, opcodes, fetch states.
package isa_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  // Opcodes live in instr[7:4]; control_unit decodes the same values.
  localparam logic [3:0] OP_MOVE = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_J    = 4'hD;
  localparam logic [3:0] OP_JAL  = 4'hE;
  localparam logic [3:0] OP_LI   = 4'hF;

  // FETCH issues the request, WAIT waits for the response, HOLD presents it to decode.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, valid/ready hand-off to decode, redirect flush.
module instr_fetch #(
  parameter int              PC_W     = isa_pkg::PC_W,
  parameter int              INSTR_W  = isa_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    instr_pc_next
);

  import isa_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               discard_q, discard_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;

  // State, PC, discard flag and the held instruction all return to reset values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next-state logic; a redirect outranks every other event in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      FETCH: begin
        state_d = WAIT;
        if (redirect_valid) begin
          discard_d = 1'b1;
          pc_d      = redirect_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = FETCH;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = FETCH;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_req      = rst_n & (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = valid_q & ~redirect_valid;
  assign instr_out     = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_pc_next = instr_pc_q + 1'b1;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level fetch model and imem model.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       imem_req, imem_req_w;
  logic [7:0] imem_addr, imem_addr_w;
  logic       imem_rvalid;
  logic [7:0] imem_rdata;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       instr_valid, instr_valid_w;
  logic       instr_ready;
  logic [7:0] instr_out, instr_out_w;
  logic [7:0] instr_pc, instr_pc_w;
  logic [7:0] instr_pc_next, instr_pc_next_w;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_pc_next(instr_pc_next)
  );

  // Second copy starting at the top of the address space to exercise PC wrap.
  instr_fetch #(.RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready),
    .instr_out(instr_out_w), .instr_pc(instr_pc_w), .instr_pc_next(instr_pc_next_w)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int vec_count;
  int fail_count;

  // Reference model: memory image, fetch bookkeeping and observed delivery log.
  logic [7:0] mem [256];
  logic [7:0] m_pc;
  logic       m_busy;
  logic       m_stale;
  logic [7:0] held[$];
  logic [7:0] m_last_instr;
  logic [7:0] m_last_pc;
  int         mem_cnt;
  logic [7:0] mem_data;
  int         cyc;
  int         log_cyc[$];
  logic [7:0] log_instr[$];
  logic [7:0] log_pc[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic resetModel();
    m_pc         = 8'h00;
    m_busy       = 1'b0;
    m_stale      = 1'b0;
    held.delete();
    m_last_instr = 8'h00;
    m_last_pc    = 8'h00;
    mem_cnt      = 0;
    cyc          = 0;
    log_cyc.delete();
    log_instr.delete();
    log_pc.delete();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases on a falling edge.
  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_imem_addr", imem_addr, 8'h00);
    checkOutput("rst_instr_valid", instr_valid, 0);
    checkOutput("rst_instr_out", instr_out, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_wrap_addr", imem_addr_w, 8'hFF);
    resetModel();
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    imem_rvalid    = 1'b0;
    instr_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, advance the model.
  task automatic applyStimulus(input logic redir, input logic [7:0] rpc, input logic rdy,
                               input logic stray, input int lat);
    logic       rv;
    logic [7:0] rd;
    logic       e_req;
    logic       e_valid;
    logic [7:0] e_next;
    rv = 1'b0;
    rd = 8'($urandom);
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = mem_data;
      end
    end else if (stray) begin
      rv = 1'b1;
    end
    imem_rvalid    = rv;
    imem_rdata     = rd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
    e_req   = !m_busy && (held.size() == 0);
    e_valid = (held.size() != 0) && !redir;
    e_next  = m_last_pc + 8'd1;
    checkOutput("imem_req", imem_req, e_req);
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("instr_valid", instr_valid, e_valid);
    checkOutput("instr_out", instr_out, m_last_instr);
    checkOutput("instr_pc", instr_pc, m_last_pc);
    checkOutput("instr_pc_next", instr_pc_next, e_next);
    if (instr_valid === 1'b1) begin
      log_cyc.push_back(cyc);
      log_instr.push_back(instr_out);
      log_pc.push_back(instr_pc);
    end
    if (redir) begin
      if (e_req) begin
        m_busy   = 1'b1;
        m_stale  = 1'b1;
        mem_cnt  = lat;
        mem_data = mem[m_pc];
      end else if (m_busy) begin
        if (rv) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end else begin
        held.delete();
      end
      m_pc = rpc;
    end else if (e_req) begin
      m_busy   = 1'b1;
      m_stale  = 1'b0;
      mem_cnt  = lat;
      mem_data = mem[m_pc];
    end else if (m_busy) begin
      if (rv) begin
        m_busy = 1'b0;
        if (!m_stale) begin
          held.push_back(rd);
          m_last_instr = rd;
          m_last_pc    = m_pc;
          m_pc         = m_pc + 8'd1;
        end
        m_stale = 1'b0;
      end
    end else if (rdy) begin
      held.delete();
    end
    cyc++;
    @(negedge clk);
  endtask

  // Directed scenarios first, then a long randomized run with occasional resets.
  initial begin
    logic       r_redir;
    logic [7:0] r_pc;
    clk            = 1'b0;
    rst_n          = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 8'h00;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    vec_count      = 0;
    fail_count     = 0;
    resetModel();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk);

    // Back-to-back fetches with a 1-cycle memory, plus the wrap copy.
    mem[8'h00] = 8'h1D;
    mem[8'h01] = 8'h2D;
    doReset();
    checkOutput("wrap_first_addr", imem_addr_w, 8'hFF);
    applyStimulus(0, 8'h00, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 0, 1);
    checkOutput("wrap_instr_pc", instr_pc_w, 8'hFF);
    checkOutput("wrap_instr_pc_next", instr_pc_next_w, 8'h00);
    applyStimulus(0, 8'h00, 1, 0, 1);
    checkOutput("wrap_second_addr", imem_addr_w, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 1);
    checkOutput("seq_pulse_count", log_cyc.size(), 2);
    checkOutput("seq_first_instr", log_instr[0], 8'h1D);
    checkOutput("seq_second_instr", log_instr[1], 8'h2D);
    checkOutput("seq_first_pc", log_pc[0], 8'h00);
    checkOutput("seq_second_pc", log_pc[1], 8'h01);
    checkOutput("seq_pulse_gap", log_cyc[1] - log_cyc[0], 3);

    // Decode stalls for five cycles while the instruction is held.
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(0, 8'h00, 0, 0, 1);
    applyStimulus(0, 8'h00, 1, 0, 1);
    checkOutput("stall_valid_cycles", log_cyc.size(), 6);
    checkOutput("stall_held_instr", log_instr[5], 8'h1D);
    checkOutput("stall_next_addr", imem_addr, 8'h01);
    applyStimulus(0, 8'h00, 1, 0, 1);

    // Redirect while waiting; the stale response must be dropped.
    mem[8'h00] = 8'hAA;
    mem[8'h40] = 8'h5C;
    doReset();
    applyStimulus(0, 8'h00, 1, 0, 2);
    applyStimulus(1, 8'h40, 1, 0, 2);
    applyStimulus(0, 8'h00, 1, 0, 1);
    checkOutput("wait_redir_addr", imem_addr, 8'h40);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 1);
    checkOutput("wait_redir_count", log_cyc.size(), 1);
    checkOutput("wait_redir_instr", log_instr[0], 8'h5C);
    checkOutput("wait_redir_pc", log_pc[0], 8'h40);

    // Redirect in the hold cycle while decode is ready: no hand-off.
    doReset();
    applyStimulus(0, 8'h00, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 0, 1);
    applyStimulus(1, 8'h80, 1, 0, 1);
    checkOutput("hold_redir_no_valid", log_cyc.size(), 0);
    checkOutput("hold_redir_addr", imem_addr, 8'h80);
    applyStimulus(0, 8'h00, 1, 0, 1);

    // Reset arriving while a 3-cycle read is outstanding.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 0, 3);
    applyStimulus(0, 8'h00, 1, 0, 3);
    doReset();
    applyStimulus(0, 8'h00, 1, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    doReset();
    for (int n = 0; n < 3000; n++) begin
      r_redir = ($urandom_range(0, 9) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? m_pc : 8'($urandom);
      applyStimulus(r_redir, r_pc, ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 19) == 0), $urandom_range(1, 4));
      if ($urandom_range(0, 599) == 0) doReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
